// File: rtl/mpcd_pkg.sv
// Shared encodings and defaults for the enir_gen timebase / reset-qualification stage.
package mpcd_pkg;

  typedef enum logic [1:0] {
    S_LOCK = 2'b00,
    S_KEY  = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  localparam int DIV_DEFAULT = 4000;
  localparam int DEB_DEFAULT = 8;

endpackage

// File: rtl/enir_gen_sync2.sv
// Two-flop synchronizer with a configurable reset value and synchronous active-high reset.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/enir_gen.sv
// Tick prescaler plus lock/key debounce FSM feeding the internal reset generator.
// Define ENIR_GEN_KEY_EN to include the reset-key path (KEY_N synchronizer and S_KEY).
module enir_gen
  import mpcd_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int DEB = DEB_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic PLL_LOCK,
  input  logic KEY_N,
  output logic TICK,
  output logic ENIR,
  output logic RSTO_N
);

  localparam int CW = $clog2(DIV);
  localparam int DW = $clog2(DEB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);

  logic [CW-1:0] cnt;
  logic [DW-1:0] deb;
  state_t        state;
  state_t        target;
  logic          cond;
  logic          legal;
  logic          lock_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign TICK = (cnt == CNT_LAST);

  sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (CLK),
    .rst (RST),
    .d   (PLL_LOCK),
    .q   (lock_s)
  );

`ifdef ENIR_GEN_KEY_EN
  logic key_s;

  sync2 #(.RST_VAL(1'b1)) u_key_sync (
    .clk (CLK),
    .rst (RST),
    .d   (KEY_N),
    .q   (key_s)
  );
`else
  logic key_unused;
  assign key_unused = KEY_N;
`endif

  // Per-state qualifying condition and the state a debounced condition leads to.
  always_comb begin
    cond   = 1'b0;
    target = S_LOCK;
    legal  = 1'b1;
    case (state)
      S_LOCK: begin
        cond   = lock_s;
        target = S_RUN;
      end
`ifdef ENIR_GEN_KEY_EN
      S_KEY: begin
        cond   = key_s;
        target = S_RUN;
      end
      S_RUN: begin
        cond   = ~key_s;
        target = S_KEY;
      end
`else
      S_RUN: begin
        cond   = 1'b0;
        target = S_RUN;
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  // Lock loss and unreachable encodings fall back to S_LOCK ahead of any debounce.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_LOCK;
      deb   <= '0;
    end else if (!legal || (state != S_LOCK && !lock_s)) begin
      state <= S_LOCK;
      deb   <= '0;
    end else if (!cond) begin
      deb <= '0;
    end else if (TICK) begin
      if (deb == DEB_LAST) begin
        state <= target;
        deb   <= '0;
      end else begin
        deb <= deb + DW'(1);
      end
    end
  end

  assign RSTO_N = (state == S_RUN);
  assign ENIR   = TICK & RSTO_N;

endmodule

// File: tb/tb_enir_gen.sv
// Directed + random bench for enir_gen (DIV=4, DEB=2) against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_enir_gen;

  localparam int DIV = 4;
  localparam int DEB = 2;
`ifdef ENIR_GEN_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic pll_lock;
  logic key_n;
  logic tick;
  logic enir;
  logic rsto_n;

  int errors = 0;
  int checks = 0;

  enir_gen #(.DIV(DIV), .DEB(DEB)) dut (
    .CLK      (clk),
    .RST      (rst),
    .PLL_LOCK (pll_lock),
    .KEY_N    (key_n),
    .TICK     (tick),
    .ENIR     (enir),
    .RSTO_N   (rsto_n)
  );

  always #5 clk = ~clk;

  // Behavioural reference: edge count since reset, input history, mode and qualified-tick run.
  typedef enum int {M_LOCK, M_KEY, M_RUN} mode_t;
  mode_t m_mode = M_LOCK;
  int    m_edges = 0;
  int    m_qual = 0;
  bit    lock_hist[$];
  bit    key_hist[$];

  function automatic bit m_tick();
    return (m_edges % DIV) == DIV - 1;
  endfunction

  function automatic bit m_lock_s();
    return (lock_hist.size() >= 2) ? lock_hist[1] : 1'b0;
  endfunction

  function automatic bit m_key_s();
    return (key_hist.size() >= 2) ? key_hist[1] : 1'b1;
  endfunction

  function automatic void model_edge(input bit r, input bit l, input bit k);
    bit    t;
    bit    ls;
    bit    ks;
    bit    want;
    mode_t dest;
    if (r) begin
      m_mode  = M_LOCK;
      m_edges = 0;
      m_qual  = 0;
      lock_hist.delete();
      key_hist.delete();
      return;
    end
    t    = m_tick();
    ls   = m_lock_s();
    ks   = m_key_s();
    want = 1'b0;
    dest = M_LOCK;
    if (m_mode != M_LOCK && !ls) begin
      m_mode = M_LOCK;
      m_qual = 0;
    end else begin
      case (m_mode)
        M_LOCK:  begin want = ls;            dest = M_RUN; end
        M_KEY:   begin want = ks;            dest = M_RUN; end
        default: begin want = KEY_EN && !ks; dest = M_KEY; end
      endcase
      if (!want) begin
        m_qual = 0;
      end else if (t) begin
        m_qual++;
        if (m_qual == DEB) begin
          m_mode = dest;
          m_qual = 0;
        end
      end
    end
    m_edges++;
    lock_hist.push_front(l);
    key_hist.push_front(k);
    if (lock_hist.size() > 2) void'(lock_hist.pop_back());
    if (key_hist.size() > 2) void'(key_hist.pop_back());
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Drive inputs for one edge, advance the model, then compare on the falling edge.
  task automatic step(input logic r, input logic l, input logic k);
    rst      = r;
    pll_lock = l;
    key_n    = k;
    @(posedge clk);
    model_edge(r, l, k);
    @(negedge clk);
    chk("tick", tick, m_tick());
    chk("rsto_n", rsto_n, m_mode == M_RUN);
    chk("enir", enir, m_tick() && (m_mode == M_RUN));
    chk("enir_gated", enir && !rsto_n, 1'b0);
  endtask

  task automatic power_up(input string tag);
    int first_rsto;
    int first_enir;
    first_rsto = -1;
    first_enir = -1;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 1'b1, 1'b1);
      if (rsto_n === 1'b1 && first_rsto < 0) first_rsto = c + 1;
      if (enir === 1'b1 && first_enir < 0) first_enir = c + 1;
    end
    chk_int({tag, "_rsto_rise_cycle"}, first_rsto, 8);
    chk_int({tag, "_first_enir_cycle"}, first_enir, 11);
  endtask

  initial begin
    int   n;
    logic saw_low;
    int   hold;
    logic rl;
    logic rk;

    rst      = 1'b1;
    pll_lock = 1'b1;
    key_n    = 1'b1;
    @(negedge clk);

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    chk_int("reset_cnt", int'(dut.cnt), 0);

    // Power-up qualification
    power_up("pwrup");

    // Short key glitch: at most one qualified tick
    saw_low = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (rsto_n !== 1'b1) saw_low = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (rsto_n !== 1'b1) saw_low = 1'b1;
    end
    chk("glitch_no_drop", saw_low, 1'b0);

    // Key held for 12 cycles, then released
    saw_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (rsto_n === 1'b0) saw_low = 1'b1;
    end
    chk("key_press_drop", saw_low, KEY_EN);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1);
    chk("key_release_run", rsto_n, 1'b1);

    // One-cycle lock loss: RSTO_N low three cycles later
    step(1'b0, 1'b0, 1'b1);
    n = 1;
    while (rsto_n === 1'b1 && n < 8) begin
      step(1'b0, 1'b1, 1'b1);
      n++;
    end
    chk_int("lock_loss_latency", n, 3);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1);
    chk("lock_recover_run", rsto_n, 1'b1);

    // Single-cycle reset in mid-run
    step(1'b1, 1'b1, 1'b1);
    chk_int("rst_pulse_cnt", int'(dut.cnt), 0);
    power_up("rerun");

    // Randomized lock/key activity with rare resets
    hold = 0;
    rl   = 1'b1;
    rk   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 12);
        rl   = ($urandom_range(0, 9) != 0);
        rk   = 1'($urandom_range(0, 1));
      end
      hold--;
      step(($urandom_range(0, 99) == 0), rl, rk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enir_gen.md
# enir_gen

Timebase and reset-qualification stage that sits directly upstream of the internal reset generator. Divides the 4 MHz system clock into a slow tick, qualifies clock-lock and the external reset key with tick-based debouncing, and emits the internal reset generator's active-low reset (RSTO_N) and its enable pulses (ENIR). ENIR pulses appear only while RSTO_N is high, so the downstream block counts qualified ticks before it releases IR_N.

## Interface
- DIV, 4000: prescaler divisor in CLK cycles per tick (4 MHz → 1 kHz); legal ≥ 2.
- DEB, 8: consecutive qualified ticks required for any state change except lock loss; legal ≥ 1.
- CLK  in  1  system clock (4 MHz).
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- PLL_LOCK  in  1  clock-stable indication, asynchronous.
- KEY_N  in  1  external reset key, active-low, asynchronous, bouncy.
- TICK  out  1  one-CLK pulse every DIV cycles, free-running.
- ENIR  out  1  one-CLK enable pulse, equal to TICK while in RUN.
- RSTO_N  out  1  active-low reset to the internal reset generator; low outside RUN.

## Operation
- Reset values: cnt=0, deb=0, state=S_LOCK, lock_s=0, key_s=1, TICK=0, ENIR=0, RSTO_N=0.
- Prescaler: cnt counts 0..DIV-1 and wraps to 0. TICK = (cnt == DIV-1), decoded from the register. Width is $clog2(DIV).
- Synchronizers: PLL_LOCK and KEY_N each pass through two flops (lock_s, key_s).
- FSM states:
  - S_LOCK. Qualifying condition: lock_s=1.
  - S_KEY. Qualifying condition: key_s=1 (key released).
  - S_RUN. Qualifying condition: key_s=0 (key pressed).
- Debounce counter deb, width $clog2(DEB+1):
  - Clears in any cycle where the state's condition is false.
  - On TICK with the condition true: if deb==DEB-1, take the transition and clear deb; otherwise increment deb.
  - Clears on every state change.
- Transitions on a debounced condition:
  - S_LOCK → S_RUN.
  - S_KEY → S_RUN.
  - S_RUN → S_KEY.
- Lock loss: lock_s=0 in S_KEY or S_RUN moves to S_LOCK on the next edge, without debounce. It has priority over every other transition.
- RSTO_N = (state==S_RUN), decoded from the state register.
- ENIR = TICK & (state==S_RUN).
- RST asserted at any time: all registers take their reset values on the next edge. The prescaler restarts from 0.

## Timing
- Cycle 0 = first edge with RST low.
- TICK first appears at cycle DIV-1, then every DIV cycles.
- Input-to-state latency: 2 cycles of synchronizer plus 1 state register.
- Debounced release happens on the DEB-th qualified TICK. RSTO_N rises 1 cycle later.
- The first ENIR after RSTO_N rises comes at the next TICK, DIV-1 cycles later.
- Lock loss drives RSTO_N low 3 cycles after PLL_LOCK falls. ENIR drops in the same cycle as RSTO_N.
- A key low pulse shorter than DEB ticks has no effect.

## Configuration
- ENIR_GEN_KEY_EN defined: KEY_N synchronizer, S_KEY and the key transitions are present.
- ENIR_GEN_KEY_EN not defined:
  - KEY_N is ignored and S_KEY is unreachable (not synthesized).
  - The FSM is S_LOCK/S_RUN only, and S_RUN leaves only on lock loss.
  - The port list is unchanged.

## Structure
- Shared package mpcd_pkg holds:
  - the state encodings S_LOCK=2'b00, S_KEY=2'b01, S_RUN=2'b10 (2'b11 illegal, recovers to S_LOCK);
  - the default DIV and DEB values.
- One sub-module, sync2: a two-flop synchronizer with a reset-value parameter and synchronous active-high reset. It is instantiated for PLL_LOCK (reset value 0) and KEY_N (reset value 1).

## Test plan
All scenarios use DIV=4, DEB=2. PLL_LOCK and KEY_N are held at 1 from reset unless stated.
- Reset: RST high for 3 cycles → TICK=0, ENIR=0, RSTO_N=0, cnt=0.
- Power-up:
  - TICK at cycles 3, 7, 11, …
  - RSTO_N=1 from cycle 8.
  - First ENIR at cycle 11, then every 4 cycles.
  - ENIR is never high while RSTO_N=0.
- Key glitch in RUN: KEY_N low for 5 cycles (one qualified tick) → RSTO_N stays 1 and ENIR continues.
- Key press held for 12 cycles in RUN:
  - RSTO_N goes low 1 cycle after the 2nd TICK with key_s=0, and ENIR stops.
  - After release, RSTO_N returns high 1 cycle after the 2nd TICK with key_s=1.
- Lock loss: PLL_LOCK low for 1 cycle in RUN → RSTO_N low 3 cycles later; release again after 2 qualified ticks.
- RST pulse for 1 cycle in mid-RUN → next edge gives RSTO_N=0 and cnt=0; power-up sequence repeats.
